// File: rtl/fa_if.sv
// Operand/result bundle for the 4-bit look-ahead adder slice.
interface fa_if;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] S;
  logic       Co;
  logic       Pg;
  logic       Gg;

  // Operand source side: drives addends, observes registered results
  modport master (
    output A, B, Cin,
    input  S, Co, Pg, Gg
  );

  // Adder side: consumes addends, drives registered results
  modport slave (
    input  A, B, Cin,
    output S, Co, Pg, Gg
  );
endinterface

// File: rtl/fa.sv
// 4-bit carry look-ahead adder with registered sum, carry-out and group P/G.
module fa (
  input  logic clk,
  input  logic rst_n,
  fa_if.slave  bus
);

  localparam int unsigned W = 4;

  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W:0]   c;
  logic         pg_d;
  logic         gg_d;
  logic [W-1:0] s_d;

  logic [W-1:0] s_q;
  logic         co_q;
  logic         pg_q;
  logic         gg_q;

  // Bit propagate/generate, flat look-ahead carries and group terms
  always_comb begin
    p    = bus.A ^ bus.B;
    g    = bus.A & bus.B;
    c[0] = bus.Cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s_d  = p ^ c[W-1:0];
    pg_d = &p;
    // Carry-out of the slice with carry-in forced low
    gg_d = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
  end

  // Capture a new result every cycle; reset clears immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= '0;
      co_q <= 1'b0;
      pg_q <= 1'b0;
      gg_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      co_q <= c[W];
      pg_q <= pg_d;
      gg_q <= gg_d;
    end
  end

  assign bus.S  = s_q;
  assign bus.Co = co_q;
  assign bus.Pg = pg_q;
  assign bus.Gg = gg_q;

endmodule

// File: tb/tb_fa.sv
// Directed-vector bench for the fa look-ahead adder slice.
module tb_fa;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  fa_if u_if ();

  fa dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin);
    u_if.A   = a;
    u_if.B   = b;
    u_if.Cin = cin;
  endtask

  // Apply one vector, then sample just after the capturing edge
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cin);
    drive(a, b, cin);
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] s, input logic co,
                           input logic pg, input logic gg);
    check({tag, ".S"},  8'(u_if.S),  8'(s));
    check({tag, ".Co"}, 8'(u_if.Co), 8'(co));
    check({tag, ".Pg"}, 8'(u_if.Pg), 8'(pg));
    check({tag, ".Gg"}, 8'(u_if.Gg), 8'(gg));
  endtask

  initial begin
    logic [4:0] sum;
    logic [3:0] av;
    logic [3:0] bv;
    logic       cv;
    logic       exp_pg;
    logic       exp_gg;

    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b1;
    drive(4'hF, 4'hF, 1'b1);

    // Asynchronous reset, before any clock edge
    #1 rst_n = 1'b0;
    #1;
    check_out("rst_async", 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_out("rst_hold", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("rst_release", 4'hF, 1'b1, 1'b0, 1'b1);

    // Basic vectors
    apply(4'b0000, 4'b0001, 1'b0);
    check_out("vec0", 4'b0001, 1'b0, 1'b0, 1'b0);
    apply(4'b0101, 4'b0010, 1'b1);
    check_out("vec1", 4'b1000, 1'b0, 1'b0, 1'b0);
    apply(4'b0111, 4'b0011, 1'b1);
    check_out("vec2", 4'b1011, 1'b0, 1'b0, 1'b0);
    apply(4'b0110, 4'b0110, 1'b0);
    check_out("vec3", 4'b1100, 1'b0, 1'b0, 1'b0);

    // Overflow and full propagate chain
    apply(4'b1111, 4'b0010, 1'b1);
    check_out("ovf", 4'b0010, 1'b1, 1'b0, 1'b1);
    apply(4'b1111, 4'b0000, 1'b1);
    check_out("prop_c1", 4'b0000, 1'b1, 1'b1, 1'b0);
    apply(4'b1111, 4'b0000, 1'b0);
    check_out("prop_c0", 4'b1111, 1'b0, 1'b1, 1'b0);

    // Exhaustive, back-to-back
    for (int i = 0; i < 512; i++) begin
      av = 4'(i >> 5);
      bv = 4'(i >> 1);
      cv = 1'(i);
      apply(av, bv, cv);
      sum    = 5'(av) + 5'(bv) + 5'(cv);
      exp_pg = ((av ^ bv) == 4'hF);
      exp_gg = ((5'(av) + 5'(bv)) > 5'd15);
      check("exh.sum", 8'({u_if.Co, u_if.S}), 8'(sum));
      check("exh.pg",  8'(u_if.Pg), 8'(exp_pg));
      check("exh.gg",  8'(u_if.Gg), 8'(exp_gg));
      check("exh.inv", 8'(u_if.Co), 8'(u_if.Gg | (u_if.Pg & cv)));
    end

    // Mid-stream reset
    apply(4'h9, 4'h8, 1'b1);
    check_out("mid_pre", 4'h2, 1'b1, 1'b0, 1'b1);
    drive(4'h3, 4'h4, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_out("mid_clear", 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_out("mid_hold", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_out("mid_rel", 4'h0, 1'b0, 1'b0, 1'b0);
    drive(4'h5, 4'hA, 1'b0);
    @(posedge clk);
    #1;
    check_out("mid_first", 4'hF, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
